// File: rtl/seg_scanner.sv
// Four-digit multiplexed scan controller for a seven-segment display.
// Picks one nibble of a shadowed 16-bit value per slot, with a guard cycle and leading-zero blanking.
module seg_scanner #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  bcd,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [15:0]   shadow;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          blanked;

  // NOTE: all state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
      idx    <= '0;
    end else begin
      if (load) shadow <= value;
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bcd        = shadow[{idx, 2'b00} +: 4];
  assign frame_tick = (cnt == CNT_MAX) && (idx == 2'd3);

  // A digit is blanked when it and every more-significant nibble are zero; digit 0 always shows.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    blanked = 1'b0;
    an      = 4'b1111;
    if (blank_lz) begin
      case (idx)
        2'd1:    blanked = (shadow[15:4] == 12'h000);
        2'd2:    blanked = (shadow[15:8] == 8'h00);
        2'd3:    blanked = (shadow[15:12] == 4'h0);
        default: blanked = 1'b0;
      endcase
    end
    if ((cnt != '0) && !blanked) an = ~(4'b0001 << idx);
  end

endmodule

// File: doc/seg_scanner.md
# seg_scanner

Four-digit time-multiplexed scan controller that sits directly upstream of the per-digit seven-segment decoder. It holds a 16-bit value of four 4-bit nibbles and selects one nibble per slot. It presents that nibble on `bcd` to the decoder and drives the matching active-low anode. Features: a per-slot ghosting guard cycle, optional leading-zero blanking, and a frame-complete strobe.

## Interface
- `CLK_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `value` input 16: displayed value; nibble i = `value[4i+3:4i]`, digit 0 = rightmost.
- `load` input 1: when high at a rising edge, `value` is captured into the shadow register.
- `blank_lz` input 1: leading-zero blanking enable; it is not registered.
- `bcd` output 4: nibble of the active slot, connected to the decoder's `bcd` input.
- `an` output 4: anode enables, active-low, at most one bit low.
- `frame_tick` output 1: one-cycle pulse at the end of digit 3's slot.

## Operation
- State registers:
  - `shadow[15:0]`
  - `cnt`, the prescaler, range 0..CLK_DIV-1, width `$clog2(CLK_DIV)`
  - `idx[1:0]`, the active digit
- Prescaler:
  - `cnt` increments every cycle and wraps from CLK_DIV-1 to 0.
  - On that wrap, `idx` increments modulo 4 (3 → 0).
- Load:
  - `load` = 1 → `shadow <= value` at the same edge.
  - `cnt` and `idx` are unaffected, so the scan position never resets on load.
  - `load` held high tracks `value` every cycle.
- `bcd` = `shadow[4*idx +: 4]`, combinational from registered state. It is valid in every cycle, including guard cycles.
- Guard: when `cnt` = 0, `an` = 4'b1111 (all digits dark) so that the `bcd` change settles before any anode turns on.
- Blanking:
  - When `blank_lz` = 1, digit i (for i > 0) is blanked when `shadow` nibbles i..3 are all zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - Blanked digit → `an` = 4'b1111 for its whole slot.
- Lit: `an` = ~(4'b0001 << `idx`) when `cnt` ≠ 0 and the digit is not blanked.
- `frame_tick` = 1 exactly when `cnt` = CLK_DIV-1 and `idx` = 3. It is combinational from state and one cycle wide.
- Nibbles 10..15 are passed through unchanged; hex display is the decoder's concern.
- Reset (asynchronous, mid-operation included): `shadow` = 0, `cnt` = 0, `idx` = 0 immediately. This gives `an` = 4'b1111, `bcd` = 4'h0, `frame_tick` = 0 while `rst` is high.

## Timing
- Slot length is CLK_DIV cycles: 1 guard cycle plus CLK_DIV-1 lit cycles. A frame is 4·CLK_DIV cycles.
- First edge after `rst` falls: `cnt` = 1, `an` = 4'b1110, `bcd` = nibble 0 of `shadow`.
- Load latency:
  - `shadow` updates at the capturing edge.
  - `bcd` and blanking reflect the new value in the following cycle. There is no other pipeline.
- Simultaneous `load` and slot wrap: both take effect at the same edge. The new slot shows the new nibble.
- Changing `blank_lz` mid-slot affects `an` in the same cycle; there is no glitch-free requirement.
- `frame_tick` is coincident with the last lit cycle of digit 3. The next cycle is the guard cycle of digit 0.

## Test plan
- Reset check (CLK_DIV = 4): assert `rst` mid-slot.
  - Required immediately: `an` = 1111, `bcd` = 0, `frame_tick` = 0.
  - After release: `an` follows the pattern 1111, 1110×3, 1111, 1101×3, ...
- Scan order: load 16'h4321, `blank_lz` = 0.
  - `bcd` sequence 1, 2, 3, 4 per slot with `an` 1110, 1101, 1011, 0111 on lit cycles.
  - `frame_tick` high once every 16 cycles, in digit 3's last cycle.
- Leading-zero blanking, `blank_lz` = 1:
  - value 16'h0050: digits 2 and 3 dark (`an` = 1111 throughout their slots); digits 0 and 1 lit.
  - value 16'h0000: only digit 0 lit.
- Load during scan: load 16'hABCD at an edge where `cnt` = 2, `idx` = 1.
  - `bcd` changes to C the next cycle.
  - `idx` and `cnt` continue uninterrupted.
- Coincident events: `load` at the `cnt` = 3, `idx` = 3 edge.
  - `frame_tick` = 1 on that cycle.
  - Next cycle: `idx` = 0, `an` = 1111, `bcd` = new nibble 0.
- Minimum divider, CLK_DIV = 2: each slot is 1 guard cycle plus 1 lit cycle; the frame is 8 cycles; `frame_tick` period is 8.
